// File: rtl/sys_issue.sv
// Issue stage for SYSTEM ops (ECALL/MRET/CSRRx): drives the exception unit for one cycle and
// returns either a CSR writeback or a fetch redirect. Optional trap timeout: SYS_ISSUE_TIMEOUT_EN.
`ifndef SYSOP_ECALL
`define SYSOP_ECALL 5'd1
`endif
`ifndef SYSOP_RET
`define SYSOP_RET 5'd2
`endif
`ifndef SYSOP_CSR_W
`define SYSOP_CSR_W 5'd3
`endif
`ifndef SYSOP_CSR_S
`define SYSOP_CSR_S 5'd4
`endif
`ifndef SYSOP_CSR_C
`define SYSOP_CSR_C 5'd5
`endif

module sys_issue #(
    parameter int TRAP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [63:0] in_pc,
    input  logic [63:0] in_rs1_data,
    input  logic [4:0]  in_uimm,
    input  logic [11:0] in_csr_addr,
    input  logic [4:0]  in_rd,
    output logic [63:0] pc,
    output logic [63:0] data1,
    output logic [4:0]  cause,
    output logic [63:0] tval,
    input  logic [63:0] csr_data,
    input  logic        trap_en,
    input  logic [63:0] trap_pc,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        err,
    output logic [1:0]  state_dbg
);

    // Handshake: an op transfers on a clk edge where in_valid && in_ready; in_ready is high only in IDLE.
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TRAP, WB} state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [4:0]  rd_q;
    logic [63:0] pc_q, data1_q, tval_q, wb_data_q, redirect_pc_q;
    logic [4:0]  wb_rd_q;
    logic [4:0]  issue_cause;
    logic        is_csr_q, in_is_csr, in_is_imm;
    logic        timeout_hit;

    assign is_csr_q  = op_q[2] | op_q[1];
    assign in_is_csr = in_op[2] | in_op[1];
    assign in_is_imm = in_op[2] & (in_op[1] | in_op[0]);

    always_comb begin
        case (op_q)
            3'd0:       issue_cause = `SYSOP_ECALL;
            3'd1:       issue_cause = `SYSOP_RET;
            3'd2, 3'd5: issue_cause = `SYSOP_CSR_W;
            3'd3, 3'd6: issue_cause = `SYSOP_CSR_S;
            default:    issue_cause = `SYSOP_CSR_C;
        endcase
    end

`ifdef SYS_ISSUE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TRAP_TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             tmo_last;
    logic             err_q;

    assign tmo_last = (tmo_cnt_q == CNT_W'(TRAP_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == WAIT_TRAP) ? tmo_cnt_q + 1'b1 : '0;
            if (timeout_hit) err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TRAP_TIMEOUT != 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Strobes are gated by rst so nothing leaks out during the reset cycle.
    always_comb begin
        state_d        = state_q;
        in_ready       = 1'b0;
        cause          = 5'd0;
        wb_valid       = 1'b0;
        redirect_valid = 1'b0;
        timeout_hit    = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    in_ready = 1'b1;
                    if (in_valid) state_d = ISSUE;
                end
                ISSUE: begin
                    cause   = issue_cause;
                    state_d = is_csr_q ? WB : WAIT_TRAP;
                end
                WAIT_TRAP: begin
                    if (trap_en) begin
                        redirect_valid = 1'b1;
                        state_d        = IDLE;
                    end
`ifdef SYS_ISSUE_TIMEOUT_EN
                    else if (tmo_last) begin
                        timeout_hit = 1'b1;
                        state_d     = IDLE;
                    end
`endif
                end
                WB: begin
                    wb_valid = (rd_q != 5'd0);
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q          <= 3'd0;
            rd_q          <= 5'd0;
            pc_q          <= '0;
            data1_q       <= '0;
            tval_q        <= '0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= '0;
            redirect_pc_q <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                op_q    <= in_op;
                rd_q    <= in_rd;
                pc_q    <= in_pc;
                tval_q  <= in_is_csr ? {52'b0, in_csr_addr} : 64'd0;
                data1_q <= !in_is_csr ? 64'd0 :
                           in_is_imm  ? {59'b0, in_uimm} : in_rs1_data;
            end
            // csr_data is only valid while cause is asserted, so capture it at the end of ISSUE.
            if (state_q == ISSUE && is_csr_q) begin
                wb_data_q <= csr_data;
                wb_rd_q   <= rd_q;
            end
            if (redirect_valid) redirect_pc_q <= trap_pc;
        end
    end

    assign pc          = pc_q;
    assign data1       = data1_q;
    assign tval        = tval_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign redirect_pc = redirect_valid ? trap_pc : redirect_pc_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_sys_issue.sv
// Directed bench for sys_issue: CSR writeback, rd=x0, ECALL redirect, back-to-back, reset, trap wait.
module tb_sys_issue;

    localparam logic [4:0] C_ECALL = 5'd1;
    localparam logic [4:0] C_RET   = 5'd2;
    localparam logic [4:0] C_W     = 5'd3;
    localparam logic [4:0] C_S     = 5'd4;
    localparam logic [4:0] C_C     = 5'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [2:0]  in_op;
    logic [63:0] in_pc, in_rs1_data;
    logic [4:0]  in_uimm, in_rd;
    logic [11:0] in_csr_addr;
    logic [63:0] pc, data1, tval, csr_data, trap_pc, wb_data, redirect_pc;
    logic [4:0]  cause, wb_rd;
    logic        trap_en, wb_valid, redirect_valid, err;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    sys_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_uimm(in_uimm), .in_csr_addr(in_csr_addr),
        .in_rd(in_rd), .pc(pc), .data1(data1), .cause(cause), .tval(tval), .csr_data(csr_data),
        .trap_en(trap_en), .trap_pc(trap_pc), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .err(err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [63:0] p, input logic [63:0] rs1,
                            input logic [4:0] uimm, input logic [11:0] csr, input logic [4:0] rd);
        in_valid = 1'b1; in_op = op; in_pc = p; in_rs1_data = rs1;
        in_uimm = uimm; in_csr_addr = csr; in_rd = rd;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_pc = '0; in_rs1_data = '0;
        in_uimm = '0; in_csr_addr = '0; in_rd = '0; csr_data = '0; trap_en = 1'b0; trap_pc = '0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (cause !== 5'd0) $display("FAIL rst_cause: got %0h want 0", cause); else n_pass++;
        n_checks++; if (pc !== 64'd0 || data1 !== 64'd0 || tval !== 64'd0) $display("FAIL rst_data: got pc=%0h d1=%0h tval=%0h want 0", pc, data1, tval); else n_pass++;
        n_checks++; if (wb_valid !== 1'b0 || redirect_valid !== 1'b0 || err !== 1'b0) $display("FAIL rst_strobes: got wb=%b rd=%b err=%b want 0", wb_valid, redirect_valid, err); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL rst_state: got %0d want 0", state_dbg); else n_pass++;
        rst = 1'b0; #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_csrrw();
        drive_op(3'd2, 64'h1000, 64'hA5, 5'd0, 12'h300, 5'd5);
        csr_data = 64'h1800;
        tick();
        in_valid = 1'b0;
        n_checks++; if (cause !== C_W) $display("FAIL csrrw_cause: got %0h want %0h", cause, C_W); else n_pass++;
        n_checks++; if (tval !== 64'h300) $display("FAIL csrrw_tval: got %0h want 300", tval); else n_pass++;
        n_checks++; if (data1 !== 64'hA5) $display("FAIL csrrw_data1: got %0h want a5", data1); else n_pass++;
        n_checks++; if (pc !== 64'h1000) $display("FAIL csrrw_pc: got %0h want 1000", pc); else n_pass++;
        n_checks++; if (in_ready !== 1'b0 || wb_valid !== 1'b0) $display("FAIL csrrw_issue_strobes: got rdy=%b wb=%b want 0", in_ready, wb_valid); else n_pass++;
        tick();
        csr_data = 64'hDEAD;
        n_checks++; if (cause !== 5'd0) $display("FAIL csrrw_cause_once: got %0h want 0", cause); else n_pass++;
        n_checks++; if (wb_valid !== 1'b1) $display("FAIL csrrw_wb_valid: got %b want 1", wb_valid); else n_pass++;
        n_checks++; if (wb_rd !== 5'd5 || wb_data !== 64'h1800) $display("FAIL csrrw_wb: got rd=%0d data=%0h want 5/1800", wb_rd, wb_data); else n_pass++;
        tick();
        n_checks++; if (wb_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL csrrw_done: got wb=%b rdy=%b want 0/1", wb_valid, in_ready); else n_pass++;
        n_checks++; if (wb_data !== 64'h1800) $display("FAIL csrrw_wb_hold: got %0h want 1800", wb_data); else n_pass++;
    endtask

    task automatic test_csrrsi_rd0();
        drive_op(3'd6, 64'h1004, 64'hFFFF, 5'd0, 12'h305, 5'd0);
        csr_data = 64'h55;
        tick();
        in_valid = 1'b0;
        n_checks++; if (cause !== C_S) $display("FAIL rsi_cause: got %0h want %0h", cause, C_S); else n_pass++;
        n_checks++; if (data1 !== 64'd0) $display("FAIL rsi_data1: got %0h want 0", data1); else n_pass++;
        tick();
        n_checks++; if (cause !== 5'd0 || wb_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL rsi_wb_cycle: got cause=%0h wb=%b rdy=%b want 0/0/0", cause, wb_valid, in_ready); else n_pass++;
        tick();
        n_checks++; if (in_ready !== 1'b1 || wb_valid !== 1'b0) $display("FAIL rsi_ready: got rdy=%b wb=%b want 1/0", in_ready, wb_valid); else n_pass++;
        // CSRRCI with a nonzero immediate takes the I-form operand path
        drive_op(3'd7, 64'h1008, 64'hFFFF, 5'd19, 12'h305, 5'd3);
        tick();
        in_valid = 1'b0;
        n_checks++; if (cause !== C_C || data1 !== 64'd19) $display("FAIL rci_issue: got cause=%0h d1=%0h want %0h/13", cause, data1, C_C); else n_pass++;
        tick(); tick();
    endtask

    task automatic test_ecall();
        trap_en = 1'b1; trap_pc = 64'h1111; #1;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL trap_in_idle: got %b want 0", redirect_valid); else n_pass++;
        trap_en = 1'b0;
        drive_op(3'd0, 64'h8000_0010, 64'h42, 5'd7, 12'h300, 5'd1);
        tick();
        in_valid = 1'b0;
        n_checks++; if (cause !== C_ECALL) $display("FAIL ecall_cause: got %0h want %0h", cause, C_ECALL); else n_pass++;
        n_checks++; if (pc !== 64'h8000_0010 || data1 !== 64'd0 || tval !== 64'd0) $display("FAIL ecall_fields: got pc=%0h d1=%0h tval=%0h want 80000010/0/0", pc, data1, tval); else n_pass++;
        tick();
        n_checks++; if (cause !== 5'd0 || redirect_valid !== 1'b0) $display("FAIL ecall_wait: got cause=%0h rv=%b want 0/0", cause, redirect_valid); else n_pass++;
        trap_en = 1'b1; trap_pc = 64'h8000_0100; #1;
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h8000_0100) $display("FAIL ecall_redirect: got rv=%b pc=%0h want 1/80000100", redirect_valid, redirect_pc); else n_pass++;
        tick();
        trap_en = 1'b0; trap_pc = 64'h0; #1;
        n_checks++; if (redirect_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL ecall_done: got rv=%b rdy=%b want 0/1", redirect_valid, in_ready); else n_pass++;
        n_checks++; if (redirect_pc !== 64'h8000_0100) $display("FAIL ecall_pc_hold: got %0h want 80000100", redirect_pc); else n_pass++;
    endtask

    task automatic test_back_to_back();
        drive_op(3'd4, 64'h1800, 64'hF0, 5'd0, 12'h341, 5'd7);
        csr_data = 64'h77;
        tick();
        n_checks++; if (cause !== C_C || data1 !== 64'hF0 || tval !== 64'h341) $display("FAIL b2b_csrrc: got cause=%0h d1=%0h tval=%0h want %0h/f0/341", cause, data1, tval, C_C); else n_pass++;
        drive_op(3'd1, 64'h2000, 64'h0, 5'd0, 12'h0, 5'd0);
        tick();
        n_checks++; if (cause !== 5'd0 || in_ready !== 1'b0) $display("FAIL b2b_wb_stall: got cause=%0h rdy=%b want 0/0", cause, in_ready); else n_pass++;
        n_checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'h77) $display("FAIL b2b_wb: got v=%b rd=%0d d=%0h want 1/7/77", wb_valid, wb_rd, wb_data); else n_pass++;
        tick();
        n_checks++; if (in_ready !== 1'b1 || cause !== 5'd0) $display("FAIL b2b_accept2: got rdy=%b cause=%0h want 1/0", in_ready, cause); else n_pass++;
        tick();
        in_valid = 1'b0;
        n_checks++; if (cause !== C_RET || pc !== 64'h2000 || data1 !== 64'd0) $display("FAIL b2b_mret: got cause=%0h pc=%0h d1=%0h want %0h/2000/0", cause, pc, data1, C_RET); else n_pass++;
        tick();
        n_checks++; if (cause !== 5'd0) $display("FAIL b2b_mret_once: got %0h want 0", cause); else n_pass++;
        trap_en = 1'b1; trap_pc = 64'h3000; #1;
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h3000) $display("FAIL b2b_redirect: got rv=%b pc=%0h want 1/3000", redirect_valid, redirect_pc); else n_pass++;
        tick();
        trap_en = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        drive_op(3'd0, 64'h4000, 64'h0, 5'd0, 12'h0, 5'd0);
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1; trap_en = 1'b1; trap_pc = 64'h5000; #1;
        n_checks++; if (redirect_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL rstmid_during: got rv=%b rdy=%b want 0/0", redirect_valid, in_ready); else n_pass++;
        tick();
        n_checks++; if (pc !== 64'd0 || wb_data !== 64'd0 || redirect_pc !== 64'd0 || wb_rd !== 5'd0) $display("FAIL rstmid_zero: got pc=%0h wbd=%0h rpc=%0h wbrd=%0d want 0", pc, wb_data, redirect_pc, wb_rd); else n_pass++;
        rst = 1'b0; #1;
        n_checks++; if (in_ready !== 1'b1 || redirect_valid !== 1'b0 || cause !== 5'd0) $display("FAIL rstmid_after: got rdy=%b rv=%b cause=%0h want 1/0/0", in_ready, redirect_valid, cause); else n_pass++;
        tick();
        n_checks++; if (redirect_valid !== 1'b0 || wb_valid !== 1'b0) $display("FAIL rstmid_no_strobe: got rv=%b wb=%b want 0/0", redirect_valid, wb_valid); else n_pass++;
        trap_en = 1'b0;
    endtask

`ifdef SYS_ISSUE_TIMEOUT_EN
    task automatic test_trap_wait();
        drive_op(3'd0, 64'h6000, 64'h0, 5'd0, 12'h0, 5'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (in_ready !== 1'b0 || err !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL tmo_wait%0d: got rdy=%b err=%b rv=%b want 0/0/0", i, in_ready, err, redirect_valid); else n_pass++;
        end
        tick();
        n_checks++; if (err !== 1'b1 || in_ready !== 1'b1) $display("FAIL tmo_err: got err=%b rdy=%b want 1/1", err, in_ready); else n_pass++;
        trap_en = 1'b1; trap_pc = 64'h7000; #1;
        n_checks++; if (redirect_valid !== 1'b0) $display("FAIL tmo_late_trap: got %b want 0", redirect_valid); else n_pass++;
        tick(); tick();
        trap_en = 1'b0;
        n_checks++; if (err !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", err); else n_pass++;
        rst = 1'b1; tick(); rst = 1'b0; #1;
        n_checks++; if (err !== 1'b0) $display("FAIL tmo_clear: got %b want 0", err); else n_pass++;
    endtask
`else
    task automatic test_trap_wait();
        drive_op(3'd1, 64'h6000, 64'h0, 5'd0, 12'h0, 5'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++; if (in_ready !== 1'b0 || err !== 1'b0 || redirect_valid !== 1'b0) $display("FAIL wait%0d: got rdy=%b err=%b rv=%b want 0/0/0", i, in_ready, err, redirect_valid); else n_pass++;
        end
        trap_en = 1'b1; trap_pc = 64'h7000; #1;
        n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 64'h7000) $display("FAIL wait_redirect: got rv=%b pc=%0h want 1/7000", redirect_valid, redirect_pc); else n_pass++;
        tick();
        trap_en = 1'b0;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL wait_done: got %b want 1", in_ready); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_csrrw();
        test_csrrsi_rd0();
        test_ecall();
        test_back_to_back();
        test_reset_mid_op();
        test_trap_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sys_issue.md
Name: sys_issue

Overview:
- Issue side of the system-op interface: accepts one decoded SYSTEM instruction (ECALL, MRET, CSRRx) from decode and drives the exception unit's pc/data1/cause/tval inputs.
- Captures the returned csr_data for register writeback.
- For ECALL/MRET, waits for trap_en/trap_pc and forwards the redirect to fetch.
- Sits between decode and the exception/CSR unit; stalls decode while an op is in flight.

Parameters:
- TRAP_TIMEOUT, 8, cycles to wait for trap_en after an ECALL/MRET issue (timeout feature only)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded system op present
- in_ready  out  1  block can accept an op
- in_op  in  3  0 ECALL, 1 MRET, 2 CSRRW, 3 CSRRS, 4 CSRRC, 5 CSRRWI, 6 CSRRSI, 7 CSRRCI
- in_pc  in  64  instruction PC
- in_rs1_data  in  64  rs1 value (register forms)
- in_uimm  in  5  immediate (I forms)
- in_csr_addr  in  12  CSR number
- in_rd  in  5  destination register
- pc  out  64  to exception unit
- data1  out  64  to exception unit
- cause  out  5  to exception unit; 5'd0 = no op
- tval  out  64  to exception unit
- csr_data  in  64  old CSR value from exception unit (combinational, valid while cause is a CSR op)
- trap_en  in  1  trap/return redirect from exception unit
- trap_pc  in  64  redirect target
- wb_valid  out  1  one-cycle writeback strobe
- wb_rd  out  5  writeback register
- wb_data  out  64  writeback value
- redirect_valid  out  1  one-cycle fetch redirect strobe
- redirect_pc  out  64  fetch target
- err  out  1  sticky trap timeout flag

Behaviour:
- Reset (rst=1 at posedge):
  - State IDLE; all outputs 0; in_ready=0 during reset.
  - Reset mid-op abandons the op; no wb/redirect is emitted.
- States: IDLE, ISSUE, WAIT_TRAP, WB.
- IDLE:
  - in_ready=1.
  - On in_valid, register the op fields and go to ISSUE.
- ISSUE (exactly one cycle):
  - in_ready=0.
  - cause is driven for this cycle only, because the exception unit acts on every cycle cause is nonzero. Holding it for two cycles is a bug (double write).
  - pc=latched in_pc.
  - CSR ops:
    - tval={52'b0, csr_addr}.
    - data1=rs1_data for register forms, {59'b0, uimm} for I forms.
    - cause=`SYSOP_CSR_W/S/C by op.
    - csr_data is sampled into wb_data at the end of the cycle; next state WB.
  - ECALL/MRET:
    - tval=0, data1=0, cause=`SYSOP_ECALL or `SYSOP_RET.
    - Next state WAIT_TRAP.
- WAIT_TRAP:
  - cause=0.
  - trap_en arrives registered, 1 cycle after ISSUE.
  - When trap_en=1: redirect_valid=1 and redirect_pc=trap_pc for one cycle; return to IDLE.
  - trap_en seen in any other state is ignored.
- WB:
  - wb_valid=1 for one cycle with wb_rd/wb_data; return to IDLE.
  - rd==0: wb_valid stays 0, but the state still passes through WB.
- Latency:
  - CSR op: in_valid accept → wb_valid 2 cycles later; next accept on the 3rd cycle.
  - ECALL/MRET: redirect 2 cycles after accept.
- Set/clear with a zero operand (rs1=x0 or uimm=0):
  - Still issued; S|0 and C&~0 leave the CSR unchanged.
  - Needed so csr_data is returned.
- All out strobes are 0 except in the states named above; data outputs hold their last value.

Optional Feature:
- Macro SYS_ISSUE_TIMEOUT_EN.
- Defined:
  - A counter starts on entry to WAIT_TRAP.
  - If TRAP_TIMEOUT cycles pass with no trap_en: err is set (sticky until rst), no redirect is emitted, and the state returns to IDLE.
- Undefined:
  - No counter; WAIT_TRAP waits indefinitely; err tied 0.

Test Plan:
- CSRRW rd=5 csr=0x300 rs1=0xA5, csr_data=0x1800 → one ISSUE cycle with cause=`SYSOP_CSR_W, tval=0x300, data1=0xA5; wb_valid next cycle, wb_rd=5, wb_data=0x1800.
- CSRRSI rd=0 uimm=0 → cause=`SYSOP_CSR_S, data1=0 for exactly one cycle; wb_valid never asserts; in_ready returns after 2 cycles.
- ECALL pc=0x8000_0010, exception returns trap_en with trap_pc=0x8000_0100 → redirect_valid one cycle, redirect_pc=0x8000_0100; cause nonzero for exactly 1 cycle.
- Back-to-back in_valid held high with CSRRC then MRET → second op accepted only after WB; two distinct single-cycle cause pulses.
- rst asserted during WAIT_TRAP, then trap_en=1 → no redirect; all outputs 0; in_ready=1 the cycle after rst drops.
- With SYS_ISSUE_TIMEOUT_EN, TRAP_TIMEOUT=8, ECALL and trap_en never asserts → err=1 after 8 cycles; no redirect; returns to IDLE; err stays high until rst.
